// File: rtl/tone_period_rx.sv
// tone_period_rx: measures the period of an asynchronous tone in clk cycles, averages
// 2**AVG_LOG2 periods and flags loss of tone. Define TONE_DIFF_IN_EN for differential input.
module tone_period_rx #(
    parameter int CNT_W    = 20,
    parameter int AVG_LOG2 = 2,
    parameter int TIMEOUT  = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             gpio_in,
`ifdef TONE_DIFF_IN_EN
    input  logic             gpio_in_n,
    output logic             diff_err,
`endif
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid,
    output logic             no_tone
);

    localparam int ACC_W = CNT_W + AVG_LOG2;
    localparam int NS_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [NS_W-1:0]  NS_LAST = NS_W'((1 << AVG_LOG2) - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    logic [2:0]       sync_p;
    logic [CNT_W-1:0] cnt;
    logic             armed;
    logic [ACC_W-1:0] acc;
    logic [NS_W-1:0]  nsamp;

    logic             rise_raw;
    logic             rise_det;
    logic             timeout_hit;
    logic             last_samp;
    logic [CNT_W-1:0] sample;
    logic [ACC_W-1:0] sum;

    // sync_p[0..1] is the synchronizer, sync_p[2] the history bit for edge detection
    assign rise_raw = sync_p[1] & ~sync_p[2];

`ifdef TONE_DIFF_IN_EN
    logic [1:0] sync_n;
    assign rise_det = rise_raw & ~sync_n[1];
`else
    assign rise_det = rise_raw;
`endif

    assign sample      = cnt + CNT_W'(1);
    assign sum         = acc + ACC_W'(sample);
    assign last_samp   = (nsamp == NS_LAST);
    // A rise in the timeout cycle takes priority so a period of exactly TIMEOUT still measures
    assign timeout_hit = armed && (cnt == TO_LAST) && !rise_det;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_p       <= '0;
            cnt          <= '0;
            armed        <= 1'b0;
            acc          <= '0;
            nsamp        <= '0;
            period_out   <= '0;
            period_valid <= 1'b0;
            no_tone      <= 1'b1;
        end else begin
            sync_p       <= {sync_p[1:0], gpio_in};
            period_valid <= 1'b0;

            if (rise_det) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (rise_det) begin
                if (!armed) begin
                    armed <= 1'b1;
                end else if (last_samp) begin
                    period_out   <= sum[AVG_LOG2 +: CNT_W];
                    period_valid <= 1'b1;
                    acc          <= '0;
                    nsamp        <= '0;
                    no_tone      <= 1'b0;
                end else begin
                    acc   <= sum;
                    nsamp <= nsamp + NS_W'(1);
                end
            end else if (timeout_hit) begin
                no_tone    <= 1'b1;
                armed      <= 1'b0;
                acc        <= '0;
                nsamp      <= '0;
                period_out <= '0;
            end
        end
    end

`ifdef TONE_DIFF_IN_EN
    // Negative leg uses the same two-stage path so both legs line up in the detect cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_n   <= '0;
            diff_err <= 1'b0;
        end else begin
            sync_n <= {sync_n[0], gpio_in_n};
            if (rise_raw && sync_n[1]) begin
                diff_err <= 1'b1;
            end
        end
    end
`endif

endmodule
